instr_fetch_queue: RTL
======================

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
- REQ-001: Parameter DEPTH, default 4: number of queue entries; SHALL be a power of two, at least 2.
- REQ-002: Parameter AW, default 2: pointer width; SHALL equal log2(DEPTH).
- REQ-003: Port clk, input, 1: single clock; all state updates on rising edge.
- REQ-004: Port reset, input, 1: synchronous, active-high reset.
- REQ-005: Port in_valid, input, 1: fetch side presents a fetched instruction.
- REQ-006: Port in_ready, output, 1: queue accepts an entry this cycle.
- REQ-007: Port in_pc, input, 32: address of the fetched instruction.
- REQ-008: Port in_instr, input, 32: fetched instruction word from ROM.
- REQ-009: Port out_valid, output, 1: head entry is available to decode.
- REQ-010: Port out_ready, input, 1: decode consumes the head entry this cycle.
- REQ-011: Port out_pc, output, 32: address of the head entry.
- REQ-012: Port out_instr, output, 32: instruction word of the head entry.
- REQ-013: Port out_misaligned, output, 1: head entry's in_pc[1:0] was nonzero.
- REQ-014: Port flush, input, 1: discard all entries (redirect from branch/jump).
- REQ-015: Port count, output, AW+1: number of valid entries held.

Function
- REQ-016: Push SHALL occur when in_valid && in_ready; store {in_misaligned, in_pc, in_instr} at wr_ptr, then advance wr_ptr.
- REQ-017: Pop SHALL occur when out_valid && out_ready; advance rd_ptr.
- REQ-018: wr_ptr and rd_ptr SHALL wrap modulo DEPTH (DEPTH-1 -> 0).
- REQ-019: in_ready SHALL equal (count != DEPTH) && !flush && !reset; no combinational dependence on out_ready.
- REQ-020: out_valid SHALL equal (count != 0) && !flush.
- REQ-021: out_pc, out_instr and out_misaligned SHALL be read from the entry at rd_ptr; their value is don't-care when out_valid is 0.
- REQ-022: No bypass: an entry pushed in cycle N SHALL first be visible on out_* in cycle N+1. Latency is 1 cycle.
- REQ-023: A push and a pop in the same cycle SHALL leave count unchanged and update both pointers.
- REQ-024: When full (count == DEPTH), in_ready SHALL be 0; a pop that cycle frees a slot, and in_ready rises the next cycle.
- REQ-025: When empty, out_valid SHALL be 0; out_ready is ignored.
- REQ-026: count SHALL be updated as +1 on push only, -1 on pop only, and unchanged otherwise. It SHALL never exceed DEPTH or go below 0.
- REQ-027: Flush asserted in cycle N SHALL zero count, wr_ptr and rd_ptr at the next edge. No push or pop SHALL take effect in cycle N.
- REQ-028: in_valid SHALL be ignored while in_ready is 0; data is held upstream per the valid/ready protocol.
- REQ-029: Once out_valid is 1, the head entry's out_* values SHALL remain stable until popped or flushed.
- REQ-030: Storage contents SHALL NOT be reset; only pointers and count are cleared.

Reset
- REQ-031: While reset is high at a clock edge, wr_ptr, rd_ptr and count SHALL become 0.
- REQ-032: While reset is high, in_ready SHALL be 0 and out_valid SHALL be 0.
- REQ-033: In the first cycle after reset deasserts, in_ready SHALL be 1, out_valid 0 and count 0.
- REQ-034: Reset asserted mid-operation (queue partially full) SHALL discard all entries; flush has no effect while reset is high.

Verification
- REQ-035: Single push: reset, then push pc=0x0, instr=0x00000013 in cycle 1 -> out_valid=1 in cycle 2 with out_pc=0x0, out_instr=0x00000013, count=1; pop -> count=0, out_valid=0.
- REQ-036: Fill/full: push pc=0x0,0x4,0x8,0xC with out_ready=0 -> count=4, in_ready=0; a fifth push with pc=0x10 held on input is not accepted. Pop once -> in_ready=1 next cycle, then pc=0x10 is accepted. Order of out_pc: 0x0,0x4,0x8,0xC,0x10.
- REQ-037: Simultaneous push/pop: with count=2, push and pop in the same cycle -> count stays 2; FIFO order is preserved across pointer wrap over 10 continuous transfers (pc 0x0..0x24).
- REQ-038: Flush: with count=3, assert flush together with in_valid=1 -> next cycle count=0, out_valid=0; the pushed entry never appears on out_*.
- REQ-039: Misaligned: push in_pc=0x6 -> out_misaligned=1 with out_pc=0x6; the next push with pc=0x8 -> out_misaligned=0.
- REQ-040: Reset mid-operation: with count=3, assert reset for 1 cycle -> count=0, in_ready=0 during reset; in_ready=1 and out_valid=0 after release.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: DEPTH-entry FIFO between fetch and decode.
// Carries pc, instr and a misaligned flag. Reset and flush clear the pointers and count, not the storage.
module instr_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_instr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_instr,
    output logic          out_misaligned,
    input  logic          flush,
    output logic [AW:0]   count
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [31:0]   pc_q    [DEPTH];
    logic [31:0]   instr_q [DEPTH];
    logic          mis_q   [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;

    // Both handshakes are gated by flush and reset, so neither can move state in those cycles.
    assign in_ready  = (count_q != FULL_CNT) && !flush && !reset;
    assign out_valid = (count_q != '0) && !flush && !reset;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign out_pc         = pc_q[rd_ptr_q];
    assign out_instr      = instr_q[rd_ptr_q];
    assign out_misaligned = mis_q[rd_ptr_q];
    assign count          = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr_q]    <= in_pc;
            instr_q[wr_ptr_q] <= in_instr;
            mis_q[wr_ptr_q]   <= |in_pc[1:0];
        end
    end

endmodule
